rr_arbiter8: RTL

- Round-robin arbiter sharing one resource among 8 requesters.
- Produces a one-hot grant plus the 3-bit encoded index of the granted requester, i.e. the 8-to-3 encoder output form, for downstream mux select.
- Grants are held while the requester keeps its request asserted.
- A hold timer preempts a long-holding requester when others are waiting.
- Sits between the request sources and the shared datapath's select logic.

---
 rtl/rr_arbiter8_if.sv | 13 +
 rtl/rr_arbiter8.sv | 108 ++++++++++
 2 files changed

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// Handshake: a requester raises req[i] and holds it until granted and for the whole
// transaction; the grant is held while req[i] stays high. Dropping req[i] releases it.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (output req, input gnt, gnt_idx, gnt_valid, timeout);
    modport slave  (input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot/encoded grant and a hold
// timer that preempts a requester monopolising the resource while others wait.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus,
    output logic          dbg_state_o
);

    localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    logic [2:0]    win;
    logic          found;
    logic [2:0]    cand;

    // Scan ptr, ptr+1, ... with 3-bit wraparound; first requester found wins.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        cand  = ptr_q;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    gnt_d   = 8'b1 << win;
                    idx_d   = win;
                    state_d = GRANT;
                end else begin
                    gnt_d = '0;
                    idx_d = '0;
                end
            end
            GRANT: begin
                if (!bus.req[idx_q]) begin
                    // Release wins over a coincident preemption, so no timeout here.
                    gnt_d   = '0;
                    idx_d   = '0;
                    ptr_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX && |(bus.req & ~gnt_q)) begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    ptr_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.timeout   = tmo_q;
    assign dbg_state_o   = state_q;

endmodule
